// File: rtl/codma_bus_arbiter.sv
// Round-robin arbiter sharing the CoDMA bus master port between NUM_REQ
// requesters. One burst is in flight at a time. Request fields are captured
// at arbitration and held on the bus until it grants. Data beats are then
// routed between the bus and the owner until the beat count is used up.
module codma_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int SIZE_W  = 4,
  localparam int OWN_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_read_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*SIZE_W-1:0] req_size_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_write_data_i,
  output logic [NUM_REQ-1:0]        req_grant_o,
  output logic [NUM_REQ-1:0]        req_read_valid_o,
  output logic [DATA_W-1:0]         req_read_data_o,
  output logic [NUM_REQ-1:0]        req_write_ready_o,
  output logic                      bus_read_o,
  output logic                      bus_write_o,
  output logic [ADDR_W-1:0]         bus_addr_o,
  output logic [SIZE_W-1:0]         bus_size_o,
  output logic [DATA_W-1:0]         bus_write_data_o,
  input  logic                      bus_grant_i,
  input  logic                      bus_read_valid_i,
  input  logic [DATA_W-1:0]         bus_read_data_i,
  input  logic                      bus_write_ready_i,
  output logic                      busy_o,
  output logic [OWN_W-1:0]          owner_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

  state_t             state, state_next;
  logic [OWN_W-1:0]   rr_ptr;
  logic [OWN_W-1:0]   owner;
  logic               is_write;
  logic [SIZE_W-1:0]  count;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] owner_hot;
  logic [OWN_W-1:0]   cand;
  logic [OWN_W-1:0]   win_idx;
  logic               win_found;
  logic               beat;

  // Pending requests and one-hot decode of the current owner
  always_comb begin
    pending   = req_read_i | req_write_i;
    owner_hot = '0;
    owner_hot[owner] = 1'b1;
  end

  // Winner: first pending index at or after rr_ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = OWN_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && pending[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A beat counts only in DATA and only in the direction of the burst
  always_comb begin
    beat = (state == S_DATA) && (is_write ? bus_write_ready_i : bus_read_valid_i);
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (win_found) state_next = S_REQ;
      S_REQ:   if (bus_grant_i) state_next = S_DATA;
      S_DATA:  if (beat && count == SIZE_W'(1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Captured request, bus strobes, beat counter and round-robin pointer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr      <= '0;
      owner       <= '0;
      is_write    <= 1'b0;
      count       <= '0;
      bus_read_o  <= 1'b0;
      bus_write_o <= 1'b0;
      bus_addr_o  <= '0;
      bus_size_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            // Read wins when both are set; the write remains requested
            owner       <= win_idx;
            bus_addr_o  <= req_addr_i[32'(win_idx)*ADDR_W +: ADDR_W];
            bus_size_o  <= req_size_i[32'(win_idx)*SIZE_W +: SIZE_W];
            is_write    <= !req_read_i[win_idx];
            bus_read_o  <= req_read_i[win_idx];
            bus_write_o <= !req_read_i[win_idx];
          end
        end
        S_REQ: begin
          if (bus_grant_i) begin
            bus_read_o  <= 1'b0;
            bus_write_o <= 1'b0;
            count       <= (bus_size_o == '0) ? SIZE_W'(1) : bus_size_o;
            rr_ptr      <= (32'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
          end
        end
        S_DATA: begin
          if (beat && count != SIZE_W'(1)) count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Combinational handshakes routed to the owner
  always_comb begin
    req_grant_o       = (state == S_REQ && bus_grant_i) ? owner_hot : '0;
    req_read_valid_o  = (beat && !is_write) ? owner_hot : '0;
    req_write_ready_o = (beat && is_write) ? owner_hot : '0;
    req_read_data_o   = bus_read_data_i;
    bus_write_data_o  = (state == S_DATA && is_write)
                        ? req_write_data_i[32'(owner)*DATA_W +: DATA_W] : '0;
    busy_o            = (state != S_IDLE);
    owner_o           = owner;
  end

endmodule

// File: tb/tb_codma_bus_arbiter.sv
// Directed bench for codma_bus_arbiter with hand-computed expectations.
module tb_codma_bus_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int SIZE_W  = 4;

  logic                      clk = 1'b0;
  logic                      reset_i;
  logic [NUM_REQ-1:0]        req_read_i, req_write_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*SIZE_W-1:0] req_size_i;
  logic [NUM_REQ*DATA_W-1:0] req_write_data_i;
  logic [NUM_REQ-1:0]        req_grant_o, req_read_valid_o, req_write_ready_o;
  logic [DATA_W-1:0]         req_read_data_o;
  logic                      bus_read_o, bus_write_o;
  logic [ADDR_W-1:0]         bus_addr_o;
  logic [SIZE_W-1:0]         bus_size_o;
  logic [DATA_W-1:0]         bus_write_data_o;
  logic                      bus_grant_i, bus_read_valid_i, bus_write_ready_i;
  logic [DATA_W-1:0]         bus_read_data_i;
  logic                      busy_o;
  logic [1:0]                owner_o;

  int checks = 0;
  int errors = 0;

  codma_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_read_i(req_read_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i),
    .req_write_data_i(req_write_data_i),
    .req_grant_o(req_grant_o), .req_read_valid_o(req_read_valid_o),
    .req_read_data_o(req_read_data_o), .req_write_ready_o(req_write_ready_o),
    .bus_read_o(bus_read_o), .bus_write_o(bus_write_o),
    .bus_addr_o(bus_addr_o), .bus_size_o(bus_size_o),
    .bus_write_data_o(bus_write_data_o), .bus_grant_i(bus_grant_i),
    .bus_read_valid_i(bus_read_valid_i), .bus_read_data_i(bus_read_data_i),
    .bus_write_ready_i(bus_write_ready_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs after driving inputs
  task automatic settle();
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    req_read_i = '0; req_write_i = '0;
    req_addr_i = '0; req_size_i = '0; req_write_data_i = '0;
    bus_grant_i = 1'b0; bus_read_valid_i = 1'b0; bus_write_ready_i = 1'b0;
    bus_read_data_i = '0;
    req_addr_i[2*ADDR_W +: ADDR_W] = 32'h0000_1000;
    req_size_i[2*SIZE_W +: SIZE_W] = 4'd4;
    req_size_i[0*SIZE_W +: SIZE_W] = 4'd1;
    req_size_i[1*SIZE_W +: SIZE_W] = 4'd1;
    req_size_i[3*SIZE_W +: SIZE_W] = 4'd1;
    settle();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_strobes", 64'({bus_read_o, bus_write_o}), 64'd0);
    check("rst_addr_size", 64'({bus_addr_o, bus_size_o}), 64'd0);
    check("rst_owner", 64'(owner_o), 64'd0);
    check("rst_hs", 64'({req_grant_o, req_read_valid_o, req_write_ready_o}), 64'd0);
    tick(); tick();
    reset_i = 1'b0;

    // Spurious read beat while idle
    bus_read_valid_i = 1'b1;
    settle();
    check("idle_spur_rv", 64'(req_read_valid_o), 64'd0);
    tick();
    check("idle_spur_busy", 64'(busy_o), 64'd0);
    bus_read_valid_i = 1'b0;

    // Single read from requester 2, granted after 3 cycles, 4 beats
    req_read_i = 4'b0100;
    tick();
    check("r2_strobe", 64'({bus_read_o, bus_write_o}), 64'b10);
    check("r2_busy", 64'(busy_o), 64'd1);
    check("r2_addr", 64'(bus_addr_o), 64'h1000);
    check("r2_size", 64'(bus_size_o), 64'd4);
    check("r2_owner", 64'(owner_o), 64'd2);
    bus_read_valid_i = 1'b1;   // spurious during REQ
    settle();
    check("r2_req_spur_rv", 64'(req_read_valid_o), 64'd0);
    check("r2_req_nogrant", 64'(req_grant_o), 64'd0);
    tick();
    check("r2_hold", 64'(bus_read_o), 64'd1);
    tick();
    bus_grant_i = 1'b1;        // grant coincident with a read beat
    settle();
    check("r2_grant", 64'(req_grant_o), 64'b0100);
    check("r2_grant_beat_ign", 64'(req_read_valid_o), 64'd0);
    tick();
    bus_grant_i = 1'b0; bus_read_valid_i = 1'b0; req_read_i = '0;
    settle();
    check("r2_strobe_fall", 64'(bus_read_o), 64'd0);
    check("r2_grant_pulse", 64'(req_grant_o), 64'd0);
    for (int b = 0; b < 4; b++) begin
      check("r2_busy_beat", 64'(busy_o), 64'd1);
      bus_read_valid_i = 1'b1;
      bus_read_data_i = 64'hD00D_0000_0000_0000 + 64'(b);
      settle();
      check("r2_rv", 64'(req_read_valid_o), 64'b0100);
      check("r2_rdata", req_read_data_o, 64'hD00D_0000_0000_0000 + 64'(b));
      tick();
    end
    bus_read_valid_i = 1'b0;
    settle();
    check("r2_done_idle", 64'(busy_o), 64'd0);

    // Reset mid-read: requester 2, size 8, reset after 2 beats
    req_size_i[2*SIZE_W +: SIZE_W] = 4'd8;
    req_read_i = 4'b0100;
    tick();
    check("rst_mid_owner", 64'(owner_o), 64'd2);
    bus_grant_i = 1'b1;
    tick();
    bus_grant_i = 1'b0; req_read_i = '0;
    for (int b = 0; b < 2; b++) begin
      bus_read_valid_i = 1'b1;
      settle();
      check("rst_mid_rv", 64'(req_read_valid_o), 64'b0100);
      tick();
    end
    reset_i = 1'b1;
    settle();
    check("rst_async_busy", 64'(busy_o), 64'd0);
    check("rst_async_rv", 64'(req_read_valid_o), 64'd0);
    check("rst_async_bus", 64'({bus_read_o, bus_write_o, bus_addr_o, bus_size_o}), 64'd0);
    check("rst_async_owner", 64'(owner_o), 64'd0);
    tick();
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("rst_after_rv", 64'(req_read_valid_o), 64'd0);
      check("rst_after_busy", 64'(busy_o), 64'd0);
      tick();
    end
    bus_read_valid_i = 1'b0;

    // Round robin from pointer 0: owners 0,1,2,3,0
    req_size_i[2*SIZE_W +: SIZE_W] = 4'd1;
    req_read_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("rr_strobe", 64'(bus_read_o), 64'd1);
      check("rr_owner", 64'(owner_o), 64'(n % 4));
      bus_grant_i = 1'b1;
      settle();
      check("rr_grant", 64'(req_grant_o), 64'(4'b0001 << (n % 4)));
      tick();
      bus_grant_i = 1'b0;
      bus_read_valid_i = 1'b1;
      settle();
      check("rr_rv", 64'(req_read_valid_o), 64'(4'b0001 << (n % 4)));
      tick();
      bus_read_valid_i = 1'b0;
      settle();
      check("rr_idle", 64'(busy_o), 64'd0);
    end
    req_read_i = '0;

    // Requester 1: read and write together, sizes 2 -> read first
    req_size_i[1*SIZE_W +: SIZE_W] = 4'd2;
    req_write_data_i[1*DATA_W +: DATA_W] = 64'hA1A1_0000_0000_0001;
    req_read_i = 4'b0010; req_write_i = 4'b0010;
    tick();
    check("rw_read_first", 64'({bus_read_o, bus_write_o}), 64'b10);
    bus_grant_i = 1'b1;
    tick();
    bus_grant_i = 1'b0; req_read_i = '0;
    for (int b = 0; b < 2; b++) begin
      bus_read_valid_i = 1'b1; bus_write_ready_i = 1'b1;
      settle();
      check("rw_rv", 64'(req_read_valid_o), 64'b0010);
      check("rw_wr_ign", 64'(req_write_ready_o), 64'd0);
      tick();
    end
    bus_read_valid_i = 1'b0; bus_write_ready_i = 1'b0;
    tick();
    check("rw_write_next", 64'({bus_read_o, bus_write_o}), 64'b01);
    check("rw_write_owner", 64'(owner_o), 64'd1);
    bus_grant_i = 1'b1;
    settle();
    check("rw_wgrant", 64'(req_grant_o), 64'b0010);
    tick();
    bus_grant_i = 1'b0; req_write_i = '0;
    bus_read_valid_i = 1'b1;   // wrong-direction beat
    settle();
    check("rw_wrongdir_rv", 64'(req_read_valid_o), 64'd0);
    check("rw_wrongdir_wr", 64'(req_write_ready_o), 64'd0);
    tick();
    bus_read_valid_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      req_write_data_i[1*DATA_W +: DATA_W] = 64'hA1A1_0000_0000_0001 + 64'(b);
      bus_write_ready_i = 1'b1;
      settle();
      check("rw_busy", 64'(busy_o), 64'd1);
      check("rw_wready", 64'(req_write_ready_o), 64'b0010);
      check("rw_wdata", bus_write_data_o, 64'hA1A1_0000_0000_0001 + 64'(b));
      tick();
    end
    bus_write_ready_i = 1'b0;
    settle();
    check("rw_done_idle", 64'(busy_o), 64'd0);

    // Requester 3: size-0 write, ready stalled 5 cycles -> one beat
    req_size_i[3*SIZE_W +: SIZE_W] = 4'd0;
    req_write_data_i[3*DATA_W +: DATA_W] = 64'h3333_4444_5555_6666;
    req_write_i = 4'b1000;
    tick();
    check("s0_strobe", 64'({bus_read_o, bus_write_o}), 64'b01);
    check("s0_size", 64'(bus_size_o), 64'd0);
    bus_grant_i = 1'b1;
    tick();
    bus_grant_i = 1'b0; req_write_i = '0;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("s0_stall_wr", 64'(req_write_ready_o), 64'd0);
      check("s0_stall_busy", 64'(busy_o), 64'd1);
      tick();
    end
    bus_write_ready_i = 1'b1;
    settle();
    check("s0_wready", 64'(req_write_ready_o), 64'b1000);
    check("s0_wdata", bus_write_data_o, 64'h3333_4444_5555_6666);
    tick();
    settle();
    check("s0_extra_ign", 64'(req_write_ready_o), 64'd0);
    check("s0_idle", 64'(busy_o), 64'd0);
    bus_write_ready_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/codma_bus_arbiter.md
# codma_bus_arbiter

Round-robin arbiter that shares the single CoDMA bus master port between `NUM_REQ` requesters (task fetch, status writeback, data channels). It accepts one read or write burst request per requester, grants one owner at a time, drives the owner's request onto the bus, and routes data beats between bus and owner until the burst completes. It sits between the CoDMA channel engines and the `BUS_IF` master.

## Interface

Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 64, data beat width
- `SIZE_W`, 4, burst size field width, in beats

Ports:
- `clk_i`  in  1  clock, all logic on rising edge
- `reset_i`  in  1  reset; asynchronous, active-high
- `req_read_i`  in  NUM_REQ  per-requester read burst request, held until its grant
- `req_write_i`  in  NUM_REQ  per-requester write burst request, held until its grant
- `req_addr_i`  in  NUM_REQ*ADDR_W  packed start addresses, requester k at `[k*ADDR_W +: ADDR_W]`
- `req_size_i`  in  NUM_REQ*SIZE_W  packed beat counts
- `req_write_data_i`  in  NUM_REQ*DATA_W  packed write data; owner's slice presented each write beat
- `req_grant_o`  out  NUM_REQ  one-hot, one-cycle pulse when the owner's request is accepted by the bus
- `req_read_valid_o`  out  NUM_REQ  one-hot read beat strobe to owner
- `req_read_data_o`  out  DATA_W  broadcast of `bus_read_data_i`
- `req_write_ready_o`  out  NUM_REQ  one-hot write beat accept to owner
- `bus_read_o`, `bus_write_o`  out  1  bus request strobes
- `bus_addr_o`  out  ADDR_W; `bus_size_o`  out  SIZE_W
- `bus_write_data_o`  out  DATA_W  owner's write data slice
- `bus_grant_i`  in  1  bus accepted current request
- `bus_read_valid_i`  in  1; `bus_read_data_i`  in  DATA_W
- `bus_write_ready_i`  in  1  bus accepted current write beat
- `busy_o`  out  1  high in REQ or DATA
- `owner_o`  out  $clog2(NUM_REQ)  current/last owner index

## Operation

- FSM states IDLE, REQ, DATA.
- IDLE: requester k is pending if `req_read_i[k] | req_write_i[k]`. The winner is the first pending index at or after `rr_ptr`, wrapping. On a winner: register `owner_o`, `bus_addr_o`, `bus_size_o`, and the direction (read wins if both are set; the write stays pending). Set `bus_read_o` or `bus_write_o`, then go to REQ.
- REQ: hold bus outputs stable. When `bus_grant_i=1`:
  - `req_grant_o[owner]=1` in the same cycle (combinational).
  - Next edge: clear bus strobes, load beat counter with size (size 0 treated as 1), set `rr_ptr = owner+1` mod NUM_REQ, go to DATA.
- DATA read: each `bus_read_valid_i` drives `req_read_valid_o[owner]` combinationally and decrements the counter.
- DATA write: `bus_write_data_o` = owner slice; each `bus_write_ready_i` drives `req_write_ready_o[owner]` and decrements.
- DATA exit: the beat with counter==1 returns the FSM to IDLE on the next edge.
- Beats seen outside DATA, or of the wrong direction, are ignored: no strobe to any requester, no counter change.
- A requester dropping its request before grant is legal. If it drops while in REQ, the arbiter still completes the already-issued bus request.
- Counter is SIZE_W bits and never wraps below 1 in DATA.

## Timing

- Reset values:
  - All outputs 0: bus strobes, addr, size, data, grants, valids, readies, `busy_o`, `owner_o`.
  - `rr_ptr=0`, state IDLE.
- Reset mid-burst abandons the transaction immediately; no strobes follow.
- Request arrival to `bus_read_o`/`bus_write_o` high: 1 cycle (request sampled at edge T, strobe visible after edge T).
- Strobe falls on the edge after `bus_grant_i`.
- `busy_o` rises with the bus strobe and falls on the edge after the last beat.
- Back-to-back: last beat in cycle T, IDLE in T+1 with arbitration, next bus strobe visible from T+2.
- Grant in the same cycle as the first read beat: the beat is ignored. The bus must not return data before grant.

## Test plan

- Single read, requester 2, addr 0x1000, size 4, grant after 3 cycles, 4 read beats → `bus_read_o` 1 cycle after request, `req_grant_o=4'b0100` pulse, `req_read_valid_o[2]` ×4 with data matching, IDLE after beat 4.
- All 4 requesters pending continuously, size 1 each → owners 0,1,2,3,0 in order; no requester granted twice before the others.
- Requester 1 asserts read and write together, sizes 2 → read burst first, then write burst; 2 `req_write_ready_o[1]` pulses, and `bus_write_data_o` equals requester 1's slice on each accepted beat.
- Size 0 write with `bus_write_ready_i` stalled 5 cycles → exactly 1 beat accepted, then IDLE.
- Reset asserted mid-read after 2 of 8 beats, then further `bus_read_valid_i` → all outputs 0 asynchronously, no `req_read_valid_o`, `rr_ptr` restarts at 0.
- Spurious `bus_read_valid_i` in IDLE/REQ, and a read beat during a write burst → ignored; counters and strobes unchanged.
